// File: rtl/sa_edge_feeder.sv
// Edge operand injector for an N x N systolic array: skews lane i by i cycles,
// drives the left/up buses with a matching active-low enable, and sequences clear/flush.
module sa_edge_feeder #(
  parameter int unsigned ARRAY_SIZE        = 4,
  parameter int unsigned BUFFER_DATA_WIDTH = 8
) (
  input  logic                                    clk,
  input  logic                                    reset_b,
  input  logic                                    start,
  input  logic [ARRAY_SIZE*BUFFER_DATA_WIDTH-1:0] a_data,
  input  logic [ARRAY_SIZE*BUFFER_DATA_WIDTH-1:0] b_data,
  input  logic                                    in_valid,
  input  logic                                    in_last,
  output logic                                    in_ready,
  output logic [ARRAY_SIZE*BUFFER_DATA_WIDTH-1:0] left_bus,
  output logic [ARRAY_SIZE*BUFFER_DATA_WIDTH-1:0] up_bus,
  output logic                                    pe_enable_b,
  output logic                                    pe_comp_enb,
  output logic                                    busy,
  output logic                                    done
);

  localparam int unsigned N         = ARRAY_SIZE;
  localparam int unsigned W         = BUFFER_DATA_WIDTH;
  localparam int unsigned FLUSH_CYC = 2 * (N - 1);
  localparam int unsigned CNT_W     = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_flush_cnt;
  logic               r_enable_b;
  logic               r_comp_enb;
  logic               r_done;

  logic               w_adv;
  logic               w_clr;

  // One advance shifts every skew chain; flush advances inject zeros.
  assign w_adv = ((r_state == S_STREAM) && in_valid) || (r_state == S_FLUSH);
  assign w_clr = (r_state == S_IDLE) && start;

  assign in_ready    = (r_state == S_STREAM);
  assign busy        = (r_state != S_IDLE);
  assign pe_enable_b = r_enable_b;
  assign pe_comp_enb = r_comp_enb;
  assign done        = r_done;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= '0;
      r_enable_b  <= 1'b1;
      r_comp_enb  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_enable_b <= ~w_adv;
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state    <= S_CLEAR;
            r_comp_enb <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_comp_enb <= 1'b0;
          r_state    <= S_STREAM;
        end
        S_STREAM: begin
          if (in_valid && in_last) begin
            if (FLUSH_CYC == 0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_FLUSH;
              r_flush_cnt <= CNT_W'(FLUSH_CYC);
            end
          end
        end
        S_FLUSH: begin
          r_flush_cnt <= r_flush_cnt - 1'b1;
          if (r_flush_cnt == CNT_W'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_comp_enb <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  // Lane g is a shift chain of depth g+1; its tail drives the bus directly.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    localparam int unsigned DEPTH = gi + 1;

    logic [W-1:0] r_left_chain [DEPTH];
    logic [W-1:0] r_up_chain   [DEPTH];
    logic [W-1:0] w_left_head;
    logic [W-1:0] w_up_head;

    assign w_left_head = (r_state == S_STREAM) ? a_data[gi*W +: W] : '0;
    assign w_up_head   = (r_state == S_STREAM) ? b_data[gi*W +: W] : '0;

    always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
        for (int unsigned s = 0; s < DEPTH; s++) begin
          r_left_chain[s] <= '0;
          r_up_chain[s]   <= '0;
        end
      end else if (w_clr) begin
        for (int unsigned s = 0; s < DEPTH; s++) begin
          r_left_chain[s] <= '0;
          r_up_chain[s]   <= '0;
        end
      end else if (w_adv) begin
        r_left_chain[0] <= w_left_head;
        r_up_chain[0]   <= w_up_head;
        for (int unsigned s = 1; s < DEPTH; s++) begin
          r_left_chain[s] <= r_left_chain[s-1];
          r_up_chain[s]   <= r_up_chain[s-1];
        end
      end
    end

    assign left_bus[gi*W +: W] = r_left_chain[DEPTH-1];
    assign up_bus[gi*W +: W]   = r_up_chain[DEPTH-1];
  end

endmodule

// File: tb/tb_sa_edge_feeder.sv
// Directed/random bench for sa_edge_feeder: per-cycle bus/enable model plus a
// behavioural 4x4 PE array whose accumulators are compared with the A*B product.
module tb_sa_edge_feeder;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXK = 16;

  logic             clk;
  logic             reset_b;
  logic             start;
  logic [N*W-1:0]   a_data;
  logic [N*W-1:0]   b_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [N*W-1:0]   left_bus;
  logic [N*W-1:0]   up_bus;
  logic             pe_enable_b;
  logic             pe_comp_enb;
  logic             busy;
  logic             done;

  sa_edge_feeder #(
    .ARRAY_SIZE       (N),
    .BUFFER_DATA_WIDTH(W)
  ) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .start      (start),
    .a_data     (a_data),
    .b_data     (b_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .left_bus   (left_bus),
    .up_bus     (up_bus),
    .pe_enable_b(pe_enable_b),
    .pe_comp_enb(pe_comp_enb),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  total = 0;
  int  bad   = 0;
  byte A [MAXK][N];   // A[k][i] = a[i][k], left-edge beat k lane i
  byte B [MAXK][N];   // B[k][j] = b[k][j], top-edge beat k lane j
  int  cur_k;

  // Behavioural PE array: accumulate left*up, forward operands right/down.
  int pl  [N][N];
  int pu  [N][N];
  int acc [N][N];
  int snap[N][N];

  function automatic int lin(int i, int j);
    if (j == 0) return int'($signed(left_bus[i*W +: W]));
    return pl[i][j-1];
  endfunction

  function automatic int uin(int i, int j);
    if (i == 0) return int'($signed(up_bus[j*W +: W]));
    return pu[i-1][j];
  endfunction

  always @(posedge clk) begin
    if (pe_comp_enb) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= 0;
          pl[i][j]  <= 0;
          pu[i][j]  <= 0;
        end
    end else if (!pe_enable_b) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= acc[i][j] + lin(i, j) * uin(i, j);
          pl[i][j]  <= lin(i, j);
          pu[i][j]  <= uin(i, j);
        end
    end
  end

  function automatic int ref_c(int i, int j);
    int s;
    s = 0;
    for (int k = 0; k < cur_k; k++) s += int'(A[k][i]) * int'(B[k][j]);
    return s;
  endfunction

  // After e advances, lane i holds beat e-i-1 (zero outside the tile).
  function automatic logic [N*W-1:0] exp_left(int e);
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      if (e - i - 1 >= 0 && e - i - 1 < cur_k) v[i*W +: W] = A[e-i-1][i];
    return v;
  endfunction

  function automatic logic [N*W-1:0] exp_up(int e);
    logic [N*W-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++)
      if (e - j - 1 >= 0 && e - j - 1 < cur_k) v[j*W +: W] = B[e-j-1][j];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_en"},    pe_enable_b, 1'b1);
    chk({tag, "_left"},  left_bus, '0);
    chk({tag, "_up"},    up_bus, '0);
    chk({tag, "_busy"},  busy, 1'b0);
    chk({tag, "_ready"}, in_ready, 1'b0);
    chk({tag, "_comp"},  pe_comp_enb, 1'b0);
    chk({tag, "_done"},  done, 1'b0);
  endtask

  task automatic rand_beats(input int k);
    for (int kk = 0; kk < k; kk++)
      for (int i = 0; i < N; i++) begin
        A[kk][i] = byte'($urandom);
        B[kk][i] = byte'($urandom);
      end
  endtask

  task automatic set_k1_directed();
    for (int i = 0; i < N; i++) begin
      A[0][i] = byte'(i + 1);
      B[0][i] = byte'(i + 5);
    end
  endtask

  // Runs one tile; abort_e > 0 asserts reset right after that many advances.
  task automatic run_tile(input int k, input int stall_beat, input int stall_len,
                          input bit poke, input int abort_e);
    int b, e, stl, tot;
    bit adv, valid;
    cur_k = k;
    tot   = k + 2*N - 2;
    b     = 0;
    e     = 0;
    stl   = stall_len;
    chk("idle_ready", in_ready, 1'b0);
    chk("idle_busy", busy, 1'b0);
    start = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("clear_comp", pe_comp_enb, 1'b1);
    chk("clear_ready", in_ready, 1'b0);
    chk("clear_busy", busy, 1'b1);
    chk("clear_en", pe_enable_b, 1'b1);
    chk("clear_left", left_bus, '0);
    @(posedge clk); #1;
    chk("stream_comp", pe_comp_enb, 1'b0);
    while (e < tot) begin
      chk("ready", in_ready, (b < k));
      start = poke ? 1'($urandom_range(1, 0)) : 1'b0;
      if (b < k) begin
        valid = !(b == stall_beat && stl > 0);
        in_valid = valid;
        if (valid) begin
          in_last = (b == k - 1);
          for (int i = 0; i < N; i++) begin
            a_data[i*W +: W] = A[b][i];
            b_data[i*W +: W] = B[b][i];
          end
          b++;
        end else begin
          in_last = 1'b1;
          a_data  = $urandom;
          b_data  = $urandom;
          stl--;
        end
        adv = valid;
      end else begin
        in_valid = 1'($urandom_range(1, 0));
        in_last  = 1'($urandom_range(1, 0));
        a_data   = $urandom;
        b_data   = $urandom;
        adv      = 1'b1;
      end
      if (adv) e++;
      @(posedge clk); #1;
      chk("enable", pe_enable_b, !adv);
      chk("left", left_bus, exp_left(e));
      chk("up", up_bus, exp_up(e));
      chk("done", done, (adv && e == tot));
      chk("busy", busy, 1'b1);
      chk("comp", pe_comp_enb, 1'b0);
      if (abort_e > 0 && e == abort_e) begin
        reset_b = 1'b0;
        #1;
        chk_reset_outputs("abort");
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        return;
      end
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    chk("end_done", done, 1'b0);
    chk("end_busy", busy, 1'b0);
    chk("end_en", pe_enable_b, 1'b1);
    chk("end_ready", in_ready, 1'b0);
    chk("end_left", left_bus, '0);
    chk("end_up", up_bus, '0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("pe_%0d_%0d", i, j), acc[i][j], ref_c(i, j));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_b  = 1'b0;
    start    = 1'b1;
    in_valid = 1'b1;
    in_last  = 1'b1;
    a_data   = $urandom;
    b_data   = $urandom;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    reset_b = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("post_release");

    set_k1_directed();
    run_tile(1, -1, 0, 1'b0, 0);

    rand_beats(3);
    for (int k = 0; k < 3; k++) A[k][3] = byte'(10 * (k + 1));
    run_tile(3, -1, 0, 1'b0, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) snap[i][j] = acc[i][j];

    run_tile(3, 1, 2, 1'b0, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("stall_same_%0d_%0d", i, j), acc[i][j], snap[i][j]);

    rand_beats(5);
    run_tile(5, 2, 3, 1'b1, 0);

    for (int t = 0; t < 4; t++) begin
      int k;
      k = $urandom_range(8, 1);
      rand_beats(k);
      run_tile(k, $urandom_range(k - 1, 0), $urandom_range(3, 0), 1'b1, 0);
    end

    rand_beats(2);
    run_tile(2, -1, 0, 1'b0, 5);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_hold_done", done, 1'b0);
      chk("abort_hold_busy", busy, 1'b0);
    end
    reset_b = 1'b1;
    @(posedge clk); #1;
    chk("abort_release_done", done, 1'b0);
    set_k1_directed();
    run_tile(1, -1, 0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sa_edge_feeder.md
Name: sa_edge_feeder

Overview:
Operand injector for the systolic PE array. It accepts K operand beats per tile: one A column slice for the left edge and one B row slice for the top edge, N lanes each. It skews lane i by i cycles and drives the array's left/up edge buses in lockstep with the array-wide active-low enable. It also issues the accumulator-clear pulse before each tile and flushes zeros until the far-corner PE has absorbed its last product.

Parameters:
ARRAY_SIZE, 4, N: PE rows/columns; lane count per edge.
BUFFER_DATA_WIDTH, 8, signed operand width per lane.

Ports:
clk  input  1  clock; all state updates on rising edge
reset_b  input  1  asynchronous active-low reset
start  input  1  begin a tile; sampled only in IDLE
a_data  input  N*BUFFER_DATA_WIDTH  left-edge operands; lane i = bits [i*W +: W]
b_data  input  N*BUFFER_DATA_WIDTH  top-edge operands; lane j = bits [j*W +: W]
in_valid  input  1  a_data/b_data beat valid
in_last  input  1  qualifies the final beat of the tile (K-th)
in_ready  output  1  beat accepted when in_valid & in_ready
left_bus  output  N*BUFFER_DATA_WIDTH  to PE[i][0].left, lane i
up_bus  output  N*BUFFER_DATA_WIDTH  to PE[0][j].up, lane j
pe_enable_b  output  1  array enable, active-low (0 = PEs accumulate/forward)
pe_comp_enb  output  1  array accumulator/pipeline clear, active-high
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse at tile completion

Behaviour:
- Reset (async, reset_b=0): state=IDLE; all skew registers=0; left_bus=up_bus=0; pe_enable_b=1; pe_comp_enb=0; done=0; flush counter=0. Release is synchronous to clk.
- FSM states: IDLE, CLEAR, STREAM, FLUSH, DONE.
- IDLE: in_ready=0. If start=1: go to CLEAR, zero all skew registers, register pe_comp_enb<=1.
- CLEAR: lasts exactly one cycle, with pe_comp_enb=1 during it. Then go to STREAM and set pe_comp_enb<=0.
- STREAM: in_ready=1 (combinational from state). A beat accepted with in_last=1 moves the FSM to FLUSH and loads the flush counter with 2*(N-1). in_last is ignored when in_valid=0.
- FLUSH: in_ready=0. Every cycle is an advance with zero input beats. After 2*(N-1) advances, go to DONE. If N=1, go straight to DONE.
- DONE: done=1 for one cycle, then IDLE. busy=0 only in IDLE.
- Advance = (STREAM & in_valid) | FLUSH.
- Skew structure, per edge: lane i is a shift chain of depth i+1.
  - On advance, the chain head loads the new lane value (zero in FLUSH) and every stage shifts.
  - With no advance, all stages hold.
  - The lane-i output is the chain tail, so lane i shows beat k on the (k+i+1)-th advance.
- pe_enable_b is registered: it is set to 0 on the same edge that performs an advance and set to 1 otherwise. Bus data and enable therefore always arrive at the PEs in the same cycle.
- Stall: with in_valid=0 in STREAM, pe_enable_b=1 next cycle and the buses hold their values, so the whole array freezes.
- Tile length: K beats give exactly K+2N-2 enable-low cycles.
  - Operand a[i][k] meets b[k][j] at PE[i][j] on advance k+i+j.
  - The last product lands at PE[N-1][N-1] on the final advance.
- start outside IDLE is ignored. pe_comp_enb pulses only once per tile.
- Operands pass through unmodified: no sign extension or arithmetic in this block.
- reset_b asserted mid-tile aborts the tile with no done pulse. The next start after release runs a clean tile.

Test Plan:
- Reset values: hold reset_b=0 with start=1 and in_valid=1 -> pe_enable_b=1, buses=0, busy=0, in_ready=0, pe_comp_enb=0. After release and start, pe_comp_enb is high exactly one cycle and in_ready rises the following cycle.
- K=1 tile, N=4, a=[1,2,3,4], b=[5,6,7,8] with in_last=1 -> pe_enable_b low for 7 consecutive cycles. left lane i=a[i] and up lane j=b[j] only on enable cycle i+1 (resp. j+1), zero elsewhere. done pulses once after the 7th cycle, then busy=0.
- K=3 back-to-back beats a_k lane3 = 10,20,30 -> left lane3 reads 0,0,0,10,20,30,0,0,0 over 9 enable-low cycles. Cross-check with a 4x4 PE array: out_data equals the A*B reference product.
- Stall: drop in_valid for 2 cycles between beat 1 and beat 2 -> pe_enable_b=1 for exactly those 2 cycles, buses hold unchanged, and the final PE results are identical to the unstalled run.
- Abort: assert reset_b=0 during FLUSH -> outputs reset immediately (asynchronous) and no done pulse. A subsequent K=1 tile matches the K=1 scenario exactly.
- start=1 pulses during STREAM and FLUSH -> no extra CLEAR and no second pe_comp_enb pulse. in_last=1 with in_valid=0 -> the FSM stays in STREAM.
